// File: rtl/aes_inv_round_ctrl.sv
// aes_inv_round_ctrl
// Iterative sequencer for the AES inverse cipher. It accepts one 128-bit
// ciphertext block, runs the initial AddRoundKey, then steps the shared
// combinational inverse-round datapath once per round while addressing the
// round-key store from key_idx = NR down to 0. It then holds the plaintext
// until the downstream stage takes it.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready ciphertext handshake, in_data (byte 0 at [127:120])
//   out_valid/out_ready plaintext handshake, out_data (same byte order)
//   key_idx           round-key index to the key store
//   round_key         key-store read data for key_idx (same cycle)
//   dp_state          state presented to the inverse-round datapath
//   dp_final          last round marker (datapath skips InvMixColumns)
//   dp_result         datapath output (combinational)
//   busy              high whenever a block is in flight
module aes_inv_round_ctrl #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [3:0]   key_idx,
    input  logic [127:0] round_key,
    output logic [127:0] dp_state,
    output logic         dp_final,
    input  logic [127:0] dp_result,
    output logic         busy
);

    localparam int unsigned KW = 4;
    localparam int unsigned DW = 128;
    localparam logic [KW-1:0] KEY_LAST = KW'(NR);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state;
    logic [DW-1:0] state_reg;

    // The state register feeds both the datapath and the output stage.
    assign dp_state = state_reg;
    assign out_data = state_reg;

    // Sequencer: state, key index, cipher state and all handshake outputs.
    // Outputs are registered with the value they must take in the next state,
    // so no input reaches in_ready or out_valid combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            state_reg <= '0;
            key_idx   <= KEY_LAST;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            dp_final  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        state_reg <= in_data;
                        state     <= INIT;
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                INIT: begin
                    // Initial AddRoundKey with the last round key.
                    state_reg <= state_reg ^ round_key;
                    key_idx   <= KEY_LAST - KW'(1);
                    dp_final  <= (KEY_LAST == KW'(1));
                    state     <= ROUND;
                end
                ROUND: begin
                    state_reg <= dp_result;
                    if (key_idx == '0) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        dp_final  <= 1'b0;
                    end else begin
                        key_idx  <= key_idx - KW'(1);
                        // Next cycle is the final round when we step to 0.
                        dp_final <= (key_idx == KW'(1));
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        key_idx   <= KEY_LAST;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    key_idx   <= KEY_LAST;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    dp_final  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// tb_aes_inv_round_ctrl
// Drives an NR=10 and an NR=14 instance with FIPS-197 vectors and random
// ciphertexts. Each instance gets a bench key store and a golden inverse-round
// datapath; expected plaintexts come from FIPS constants or from a textbook
// inverse-cipher model built on GF(2^8) arithmetic.
module tb_aes_inv_round_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    logic         in_valid  [2];
    logic         in_ready  [2];
    logic [127:0] in_data   [2];
    logic         out_valid [2];
    logic         out_ready [2];
    logic [127:0] out_data  [2];
    logic [3:0]   key_idx   [2];
    logic [127:0] round_key [2];
    logic [127:0] dp_state  [2];
    logic         dp_final  [2];
    logic [127:0] dp_result [2];
    logic         busy      [2];

    logic [127:0] rk [2][16];

    int cyc = 0;
    int ntests = 0;
    int nfail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- GF(2^8) and AES primitives ----------------
    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (0 maps to 0).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] r, p;
        r = 8'h01;
        p = a;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] x;
        x = gf_inv(b);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return gf_inv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
    endfunction

    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [7:0] mix_coef(input int k);
        case (k)
            0:       return 8'h0e;
            1:       return 8'h0b;
            2:       return 8'h0d;
            default: return 8'h09;
        endcase
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] acc;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(mix_coef((j - r + 4) % 4), s[127-8*(j+4*c) -: 8]);
                o[127-8*(r+4*c) -: 8] = acc;
            end
        return o;
    endfunction

    function automatic logic [127:0] dp_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic fin);
        logic [127:0] t;
        t = inv_sub_bytes(inv_shift_rows(s)) ^ k;
        return fin ? t : inv_mix_columns(t);
    endfunction

    function automatic int nr_of(input int d);
        return (d == 0) ? 10 : 14;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Standard key expansion; a 128-bit key sits in the upper half of key.
    task automatic expand_key(input int d, input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        int nr, total;
        nr = nk + 6;
        total = 4 * (nr + 1);
        rc = 8'h01;
        for (int i = 0; i < 60; i++) w[i] = '0;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < total; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                t = sub_word(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++) rk[d][r] = '0;
        for (int r = 0; r <= nr; r++) rk[d][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Textbook inverse cipher over the whole block.
    function automatic logic [127:0] ref_decrypt(input logic [127:0] ct, input int d);
        logic [127:0] s;
        int nr;
        nr = nr_of(d);
        s = ct ^ rk[d][nr];
        for (int r = nr - 1; r >= 0; r--) begin
            s = inv_sub_bytes(inv_shift_rows(s)) ^ rk[d][r];
            if (r > 0) s = inv_mix_columns(s);
        end
        return s;
    endfunction

    // ---------------- key store, datapath and DUTs ----------------
    assign round_key[0] = rk[0][key_idx[0]];
    assign round_key[1] = rk[1][key_idx[1]];
    assign dp_result[0] = dp_round(dp_state[0], round_key[0], dp_final[0]);
    assign dp_result[1] = dp_round(dp_state[1], round_key[1], dp_final[1]);

    aes_inv_round_ctrl #(.NR(10)) u_dut10 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .key_idx(key_idx[0]), .round_key(round_key[0]),
        .dp_state(dp_state[0]), .dp_final(dp_final[0]), .dp_result(dp_result[0]),
        .busy(busy[0])
    );

    aes_inv_round_ctrl #(.NR(14)) u_dut14 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .key_idx(key_idx[1]), .round_key(round_key[1]),
        .dp_state(dp_state[1]), .dp_final(dp_final[1]), .dp_result(dp_result[1]),
        .busy(busy[1])
    );

    // ---------------- checking and sequencing tasks ----------------
    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        ntests++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Offer in_data[d] until accepted; acc is the accepting edge number.
    // Returns at the negedge of the INIT cycle with in_valid still asserted.
    task automatic send(input int d, output int acc);
        in_valid[d] = 1'b1;
        for (int i = 0; i < 100 && !in_ready[d]; i++) @(negedge clk);
        if (!in_ready[d]) begin
            check("send_timeout", 128'(in_ready[d]), 128'(1));
            acc = -1;
            return;
        end
        acc = cyc + 1;
        @(negedge clk);
    endtask

    // Follows one block from INIT through the output handshake.
    task automatic run_block(input int d, input logic [127:0] ct, input logic [127:0] exp,
                             input int acc, input int bp);
        int nr;
        nr = nr_of(d);
        out_ready[d] = (bp == 0);
        check("init_key_idx", 128'(key_idx[d]), 128'(nr));
        check("init_state", dp_state[d], ct);
        check("init_in_ready", 128'(in_ready[d]), 128'(0));
        check("init_busy", 128'(busy[d]), 128'(1));
        check("init_final", 128'(dp_final[d]), 128'(0));
        for (int k = nr - 1; k >= 0; k--) begin
            @(negedge clk);
            check("round_key_idx", 128'(key_idx[d]), 128'(k));
            check("round_final", 128'(dp_final[d]), 128'(k == 0));
            check("round_out_valid", 128'(out_valid[d]), 128'(0));
        end
        @(negedge clk);
        check("done_out_valid", 128'(out_valid[d]), 128'(1));
        check("latency", 128'(cyc - acc), 128'(nr + 1));
        check("out_data", out_data[d], exp);
        check("done_in_ready", 128'(in_ready[d]), 128'(0));
        check("done_final", 128'(dp_final[d]), 128'(0));
        for (int i = 0; i < bp; i++) begin
            @(negedge clk);
            check("bp_out_valid", 128'(out_valid[d]), 128'(1));
            check("bp_out_data", out_data[d], exp);
            check("bp_in_ready", 128'(in_ready[d]), 128'(0));
            check("bp_key_idx", 128'(key_idx[d]), 128'(0));
        end
        out_ready[d] = 1'b1;
        @(negedge clk);
        check("hs_out_valid", 128'(out_valid[d]), 128'(0));
        check("hs_in_ready", 128'(in_ready[d]), 128'(1));
        check("hs_busy", 128'(busy[d]), 128'(0));
        check("hs_key_idx", 128'(key_idx[d]), 128'(nr));
    endtask

    task automatic check_reset_outputs(input string tag);
        for (int d = 0; d < 2; d++) begin
            check({tag, "_in_ready"}, 128'(in_ready[d]), 128'(1));
            check({tag, "_out_valid"}, 128'(out_valid[d]), 128'(0));
            check({tag, "_busy"}, 128'(busy[d]), 128'(0));
            check({tag, "_key_idx"}, 128'(key_idx[d]), 128'(nr_of(d)));
            check({tag, "_final"}, 128'(dp_final[d]), 128'(0));
            check({tag, "_out_data"}, out_data[d], 128'(0));
        end
    endtask

    // ---------------- stimulus ----------------
    localparam logic [127:0] C1_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C3_CT = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;

    initial begin
        int acc1, acc2, hs;
        logic [127:0] ct, ct2;

        expand_key(0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 4);
        expand_key(1, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8);

        // Reset with random inputs toggling.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            for (int d = 0; d < 2; d++) begin
                in_valid[d]  = 1'($urandom);
                out_ready[d] = 1'($urandom);
                in_data[d]   = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            check_reset_outputs("reset");
        end
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
        end
        rst_n = 1'b1;
        @(negedge clk);

        // FIPS-197 C.1 on the NR=10 instance.
        in_data[0] = C1_CT;
        send(0, acc1);
        in_valid[0] = 1'b0;
        run_block(0, C1_CT, PT, acc1, 0);

        // Back-pressure with a second block offered during DONE.
        ct2 = {$urandom, $urandom, $urandom, $urandom};
        in_data[0] = C1_CT;
        send(0, acc1);
        in_data[0] = ct2;
        run_block(0, C1_CT, PT, acc1, 6);
        hs = cyc;
        send(0, acc2);
        in_valid[0] = 1'b0;
        check("bp_second_accept", 128'(acc2), 128'(hs + 1));
        run_block(0, ct2, ref_decrypt(ct2, 0), acc2, 0);

        // Back-to-back with in_valid and out_ready held high.
        in_data[0] = C1_CT;
        send(0, acc1);
        run_block(0, C1_CT, PT, acc1, 0);
        send(0, acc2);
        in_valid[0] = 1'b0;
        check("b2b_spacing", 128'(acc2 - acc1), 128'(13));
        run_block(0, C1_CT, PT, acc2, 0);

        // Reset while key_idx = 5.
        in_data[0] = {$urandom, $urandom, $urandom, $urandom};
        send(0, acc1);
        in_valid[0] = 1'b0;
        for (int i = 0; i < 20 && key_idx[0] != 4'd5; i++) @(negedge clk);
        check("mid_reset_reach5", 128'(key_idx[0]), 128'(5));
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        in_data[0] = C1_CT;
        send(0, acc1);
        in_valid[0] = 1'b0;
        run_block(0, C1_CT, PT, acc1, 0);

        // FIPS-197 C.3 on the NR=14 instance.
        in_data[1] = C3_CT;
        send(1, acc1);
        in_valid[1] = 1'b0;
        run_block(1, C3_CT, PT, acc1, 0);

        // Random blocks on both instances against the inverse-cipher model.
        for (int n = 0; n < 8; n++) begin
            int d, bp;
            d  = int'($urandom_range(0, 1));
            bp = int'($urandom_range(0, 3));
            ct = {$urandom, $urandom, $urandom, $urandom};
            in_data[d] = ct;
            send(d, acc1);
            in_valid[d] = 1'b0;
            run_block(d, ct, ref_decrypt(ct, d), acc1, bp);
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/aes_inv_round_ctrl.md
# aes_inv_round_ctrl

Iterative sequencer for the AES inverse cipher. It accepts one 128-bit ciphertext block, runs it through a shared combinational inverse-round datapath (InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns) once per round, and addresses the round-key store. It owns the state register and the ready/valid handshakes on both sides. It sits between the block input buffer and the plaintext output stage.

## Interface
- NR, 10: number of rounds. Legal values are 10, 12 and 14 (AES-128/192/256).
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  ciphertext block offered.
- in_ready  out  1  controller can accept a block.
- in_data  in  128  ciphertext, byte 0 at [127:120].
- out_valid  out  1  plaintext block available.
- out_ready  in  1  downstream accepts the block.
- out_data  out  128  plaintext, same byte order as in_data.
- key_idx  out  4  round-key index to the key store.
- round_key  in  128  key-store read data for key_idx (combinational, same cycle).
- dp_state  out  128  state presented to the inverse-round datapath.
- dp_final  out  1  marks the last round; the datapath must skip InvMixColumns.
- dp_result  in  128  datapath output (combinational).
- busy  out  1  high in every state except IDLE.

## Operation
- The FSM has four states: IDLE, INIT, ROUND, DONE. Encoding is free.
- IDLE:
  - in_ready = 1, key_idx = NR.
  - On in_valid & in_ready: state_reg <= in_data, go to INIT.
- INIT (1 cycle):
  - key_idx = NR.
  - state_reg <= state_reg ^ round_key (initial AddRoundKey).
  - key_idx <= NR-1, go to ROUND.
- ROUND:
  - dp_state = state_reg, dp_final = (key_idx == 0).
  - state_reg <= dp_result every cycle.
  - If key_idx == 0, go to DONE and hold key_idx at 0. Otherwise key_idx <= key_idx - 1.
- DONE:
  - out_valid = 1, out_data = state_reg.
  - On out_ready, go to IDLE and set key_idx <= NR.
- in_ready is 0 in INIT, ROUND and DONE. in_valid in those states is ignored; the block is not consumed.
- out_valid is 0 outside DONE. out_data equals state_reg at all times but is meaningful only while out_valid is high.
- dp_state always equals state_reg. dp_final is 0 outside ROUND.
- key_idx is a 4-bit down-counter. It never wraps below 0 and never exceeds NR.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Timing
- Reset (asynchronous assert, synchronous release of effect): FSM = IDLE, state_reg = 0, key_idx = NR.
  - Outputs during reset: in_ready = 1, out_valid = 0, busy = 0, dp_final = 0, out_data = 0.
- Latency:
  - Accepting edge E0 leads to INIT in cycle E0..E1.
  - ROUND runs NR cycles, with key_idx NR-1 down to 0.
  - out_valid rises after edge E0+NR+1 (E0+11 for NR = 10).
- The handshake completes on the edge where out_valid & out_ready are both high. in_ready returns 1 on the next cycle.
- Minimum spacing between accepted blocks is NR+3 cycles (NR = 10: 13 cycles) when out_ready is held high.
- Back-pressure: out_ready low holds DONE indefinitely. out_data, out_valid and key_idx stay stable, and in_ready stays 0.
- Reset mid-operation: asserting rst_n in any state aborts the block immediately and drops out_valid. No partial result is ever presented.
- in_valid and out_ready high in the same cycle: only the transition for the current state applies. A block is never accepted in DONE.

## Test plan
- Reset check: hold rst_n = 0 with random inputs -> in_ready = 1, out_valid = 0, busy = 0, key_idx = 10, dp_final = 0.
- FIPS-197 C.1 vector:
  - Setup: bench key store expanded from key 000102030405060708090a0b0c0d0e0f, plus a golden inverse-round model.
  - Stimulus: in_data 69c4e0d86a7b0430d8cdb78070b4c55a.
  - Expected: out_data 00112233445566778899aabbccddeeff with out_valid exactly 11 edges after acceptance; key_idx sequence 10,10,9,…,0; dp_final high only in the key_idx = 0 cycle.
- Back-pressure:
  - Stimulus: hold out_ready = 0 for 6 cycles after out_valid rises, and drive in_valid = 1 with a second block during that time.
  - Expected: out_data stable, in_ready = 0, second block not accepted; it is accepted the cycle after the output handshake.
- Back-to-back: two C.1 blocks, in_valid and out_ready always 1 -> both outputs correct, second acceptance edge exactly 13 cycles after the first.
- Mid-round reset: pulse rst_n low while key_idx = 5 -> outputs return to reset values asynchronously; a following C.1 block decrypts correctly.
- NR = 14 configuration with the FIPS-197 C.3 vector:
  - Stimulus: ciphertext 8ea2b7ca516745bfeafc49904b496089.
  - Expected: plaintext 00112233445566778899aabbccddeeff; out_valid 15 edges after acceptance.
